// File: rtl/divmmc.sv
// DivMMC controller: port decode, esxDOS automap and SD card SPI master.
// Overlay outputs feed the memory block for the 0x0000-0x3FFF region.
module divmmc #(
  parameter int SPIDIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        cpuM1,
  input  logic        cpuMreq,
  input  logic        cpuIorq,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [15:0] cpuA,
  input  logic [7:0]  cpuDi,
  output logic [7:0]  cpuDo,
  output logic        ioDo,
  output logic        divMap,
  output logic        divRam,
  output logic [3:0]  divPage,
  output logic        spiCs,
  output logic        spiCk,
  output logic        spiDo,
  input  logic        spiDi
);

  localparam logic [7:0] PORT_CTL = 8'hE3;
  localparam logic [7:0] PORT_CS  = 8'hE7;
  localparam logic [7:0] PORT_SPI = 8'hEB;
  localparam logic [3:0] DIVM1    = 4'(SPIDIV - 1);

  typedef enum logic {IDLE, SHIFT} spiState_t;

  logic       prevWr;
  logic       prevRd;
  logic       conMem;
  logic       mapRam;
  logic [3:0] bank;
  logic       autoMap;
  logic       mapPend;
  logic       unmapPend;

  spiState_t  state;
  logic [3:0] divCnt;
  logic [2:0] bitCnt;
  logic [7:0] txReg;
  logic [7:0] rxReg;
  logic [7:0] rdData;

  logic       ioCycle;
  logic       fetch;
  logic       wrEdge;
  logic       rdEdge;
  logic       wrCtl;
  logic       wrCs;
  logic       wrSpi;
  logic       rdSpi;
  logic       spiStart;
  logic [7:0] txData;
  logic       instantHit;
  logic       entryHit;
  logic       exitHit;

  assign ioCycle  = ~cpuIorq & cpuM1;
  assign fetch    = ~cpuM1 & ~cpuMreq;
  assign wrEdge   = ce & ~cpuWr & prevWr;
  assign rdEdge   = ce & ~cpuRd & prevRd;
  assign wrCtl    = ioCycle & wrEdge & (cpuA[7:0] == PORT_CTL);
  assign wrCs     = ioCycle & wrEdge & (cpuA[7:0] == PORT_CS);
  assign wrSpi    = ioCycle & wrEdge & (cpuA[7:0] == PORT_SPI);
  assign rdSpi    = ioCycle & rdEdge & (cpuA[7:0] == PORT_SPI);
  assign spiStart = wrSpi | rdSpi;
  assign txData   = wrSpi ? cpuDi : 8'hFF;

  assign instantHit = fetch & (cpuA[15:8] == 8'h3D);
  assign exitHit    = cpuA[15:3] == 13'h03FF;

  // Fixed esxDOS trap addresses that map after the current M1 completes
  always_comb begin
    entryHit = 1'b0;
    unique case (cpuA)
      16'h0000, 16'h0008, 16'h0038,
      16'h0066, 16'h04C6, 16'h0562: entryHit = 1'b1;
      default: entryHit = 1'b0;
    endcase
  end

  assign divMap  = conMem | autoMap | instantHit;
  assign divRam  = mapRam & ~conMem;
  assign divPage = bank;
  assign cpuDo   = rdData;
  assign ioDo    = ioCycle & ~cpuRd & (cpuA[7:0] == PORT_SPI);

  // Previous-strobe flags so each bus access acts only once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prevWr <= 1'b1;
      prevRd <= 1'b1;
    end else if (ce) begin
      prevWr <= cpuWr;
      prevRd <= cpuRd;
    end
  end

  // Control and card-select registers; MAPRAM can only be set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conMem <= 1'b0;
      mapRam <= 1'b0;
      bank   <= 4'd0;
      spiCs  <= 1'b1;
    end else begin
      if (wrCtl) begin
        conMem <= cpuDi[7];
        mapRam <= mapRam | cpuDi[6];
        bank   <= cpuDi[3:0];
      end
      if (wrCs) spiCs <= cpuDi[0];
    end
  end

  // Automap: instant 0x3Dxx entry, delayed entry/exit resolved at M1 end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      autoMap   <= 1'b0;
      mapPend   <= 1'b0;
      unmapPend <= 1'b0;
    end else if (ce) begin
      if (fetch) begin
        if (instantHit) autoMap <= 1'b1;
        if (entryHit) mapPend <= 1'b1;
        if (exitHit) unmapPend <= 1'b1;
      end else if (cpuM1) begin
        if (unmapPend) autoMap <= 1'b0;
        else if (mapPend) autoMap <= 1'b1;
        mapPend   <= 1'b0;
        unmapPend <= 1'b0;
      end
    end
  end

  // SPI mode 0 master; a new access while busy aborts and restarts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      divCnt <= 4'd0;
      bitCnt <= 3'd0;
      txReg  <= 8'hFF;
      rxReg  <= 8'hFF;
      rdData <= 8'hFF;
      spiCk  <= 1'b0;
      spiDo  <= 1'b1;
    end else if (spiStart) begin
      if (state == SHIFT) rdData <= rxReg;
      state  <= SHIFT;
      divCnt <= 4'd0;
      bitCnt <= 3'd0;
      txReg  <= txData;
      spiCk  <= 1'b0;
      spiDo  <= txData[7];
    end else if (state == SHIFT) begin
      if (divCnt == DIVM1) begin
        divCnt <= 4'd0;
        spiCk  <= ~spiCk;
        if (!spiCk) begin
          rxReg <= {rxReg[6:0], spiDi};
        end else if (bitCnt == 3'd7) begin
          state  <= IDLE;
          rdData <= rxReg;
          spiDo  <= 1'b1;
        end else begin
          bitCnt <= bitCnt + 3'd1;
          txReg  <= {txReg[6:0], 1'b1};
          spiDo  <= txReg[6];
        end
      end else begin
        divCnt <= divCnt + 4'd1;
      end
    end
  end

endmodule
